rca_seq_controller: RTL and testbench
=====================================

Name: rca_seq_controller

Overview:
Sequencing controller that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple-carry slice over WIDTH/4 cycles. The carry is chained between slices through a register. The block has valid/ready handshakes on both operand input and result output. It sits between a register-file/bus front end and the arithmetic datapath, for area-constrained builds where a full-width adder is too costly.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived (localparam), number of 4-bit slice passes per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand set presented
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in to least-significant slice
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered sum
c_out  output  1  registered carry-out of most-significant slice
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset state:
  - state=IDLE, slice index=0, carry register=0
  - operand registers=0, sum=0, c_out=0
  - out_valid=0, busy=0
  - in_ready=1 from the first cycle after reset deasserts
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into operand registers; carry register<=c_in; index<=0; sum<=0; go to RUN.
  - With no handshake: hold.
- RUN, one slice per cycle:
  - Slice inputs: a_reg[4*idx+:4], b_reg[4*idx+:4], carry register.
  - sum[4*idx+:4] <= slice sum; carry register <= slice carry; idx <= idx+1.
  - When idx==NSLICE-1: c_out <= slice carry; go to DONE.
  - in_ready=0 and input handshakes are ignored.
- DONE:
  - out_valid=1; sum and c_out stay stable until out_valid&&out_ready.
  - On that handshake: go to IDLE and drop out_valid.
  - No new operand is accepted in the same cycle.
- Latency: accept edge at cycle T. out_valid rises after edge T+NSLICE. Minimum issue interval is NSLICE+2 cycles.
- Arithmetic: unsigned modulo 2^WIDTH; {c_out,sum} = a+b+c_in exactly.
- Boundary conditions:
  - WIDTH=4 (NSLICE=1): RUN lasts exactly one cycle.
  - All-ones + 1: carry ripples across every slice boundary via the register.
  - The index never exceeds NSLICE-1; the index counter is $clog2(NSLICE)+1 bits, with no wrap hazard.
  - Input changes during RUN/DONE have no effect (operands are registered).
  - out_ready asserted while not in DONE is ignored.
  - Reset asserted in any state: on the next edge all registers return to their reset values and the in-flight result is discarded, with no out_valid pulse.

Optional Feature:
- Macro: RCA_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered at the same edge as c_out.
  - ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB, computed from the final slice.
  - Reset value 0; held stable with sum in DONE.
- Undefined: port ovf is absent and no extra logic is generated.

Decomposition:
- Package rca_seq_pkg:
  - localparam SLICE_W=4
  - typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t
  - function slice_count(width) returning width/SLICE_W
- Sub-module rca4_slice: purely combinational 4-bit ripple-carry adder (inputs a[3:0], b[3:0], ci; outputs s[3:0], co; plus c3 = carry into bit 3 for the ovf option), instantiated once.
- The controller holds the FSM, index, operand, carry and result registers.

Test Plan:
- Basic add, WIDTH=16: a=0x1234, b=0x4321, c_in=1 → sum=0x5556, c_out=0; out_valid rises exactly 4 cycles after accept edge; busy high throughout.
- Full ripple: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1. Also a=0xFFFF, b=0xFFFF, c_in=1 → sum=0xFFFF, c_out=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → sum/c_out/out_valid stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 at idx=2 → next edge sum=0, c_out=0, out_valid=0, in_ready=1; no result is ever emitted for that operation.
- WIDTH=4 instance: a=0x9, b=0x8, c_in=0 → sum=0x1, c_out=1, out_valid 1 cycle after accept. Back-to-back ops are issued at the NSLICE+2 interval with a scoreboard over 1000 random vectors versus a+b+c_in.
- With RCA_SEQ_OVF_EN, WIDTH=16:
  - 0x7FFF+0x0001 → sum=0x8000, ovf=1, c_out=0
  - 0x8000+0xFFFF → sum=0x7FFF, ovf=1, c_out=1
  - 0x0001+0xFFFF → ovf=0

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller.
//   SLICE_W         : width of the single time-multiplexed adder slice
//   rca_seq_state_t : controller FSM states
//   slice_count()   : number of slice passes for a given operand width
package rca_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/rca4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (present only when RCA_SEQ_OVF_EN is defined,
//          used for signed overflow detection on the top slice)
module rca4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic       c3
`endif
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[4];

`ifdef RCA_SEQ_OVF_EN
  assign c3 = c[3];
`endif

endmodule

// File: rtl/rca_seq_controller.sv
// Sequencing controller: computes {c_out,sum} = a + b + c_in over WIDTH/4
// cycles using one shared 4-bit ripple-carry slice; the carry between
// passes is held in a register.
// Optional macro RCA_SEQ_OVF_EN adds a registered signed-overflow output.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, c_in           : operands and carry-in
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, c_out           : registered result
//   busy                 : high in RUN or DONE
//   ovf                  : signed overflow (RCA_SEQ_OVF_EN only)
module rca_seq_controller
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = slice_count(WIDTH);
  localparam int IDX_W  = $clog2(NSLICE) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("rca_seq_controller: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
`ifdef RCA_SEQ_OVF_EN
  logic               sl_c3;
`endif

  // Select the operand nibbles for the current pass.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) begin
        sl_a = a_reg[i*SLICE_W +: SLICE_W];
        sl_b = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  rca4_slice u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
`ifdef RCA_SEQ_OVF_EN
    ,
    .c3 (sl_c3)
`endif
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
            sum   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) sum[i*SLICE_W +: SLICE_W] <= sl_s;
          end
          carry <= sl_co;
          if (idx == LAST_IDX) begin
            // Park the index at 0 so it never runs past the last slice.
            idx   <= '0;
            c_out <= sl_co;
`ifdef RCA_SEQ_OVF_EN
            ovf   <= sl_c3 ^ sl_co;
`endif
            state <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_controller.sv
// Directed bench for rca_seq_controller: a WIDTH=16 and a WIDTH=4 instance.
// Define RCA_SEQ_OVF_EN to also exercise the overflow output.
module tb_rca_seq_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=16 instance
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, co16, busy16, ci16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
`ifdef RCA_SEQ_OVF_EN
  logic        ovf16, ovf4;
`endif

  // WIDTH=4 instance
  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, co4, busy4, ci4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, s4;

  rca_seq_controller #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .c_in(ci16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .c_out(co16), .busy(busy16)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf16)
`endif
  );

  rca_seq_controller #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .c_in(ci4), .out_valid(ov4), .out_ready(or4),
    .sum(s4), .c_out(co4), .busy(busy4)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit operation; hold = cycles of out_ready=0 in DONE, with a
  // stray in_valid pulse that must be ignored.
  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tci, input logic [15:0] es, input logic eco, input int hold);
    a16 = ta; b16 = tb_; ci16 = tci; iv16 = 1'b1;
    tick();                       // accept edge
    iv16 = 1'b0;
    chk({tag, " busy_run"}, 32'(busy16), 32'd1);
    chk({tag, " ready_run"}, 32'(ir16), 32'd0);
    chk({tag, " ov_run0"}, 32'(ov16), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, " ov_early"}, 32'(ov16), 32'd0);
      chk({tag, " busy"}, 32'(busy16), 32'd1);
    end
    tick();                       // accept + 4
    chk({tag, " ov"}, 32'(ov16), 32'd1);
    chk({tag, " sum"}, 32'(s16), 32'(es));
    chk({tag, " cout"}, 32'(co16), 32'(eco));
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin a16 = 16'hAAAA; b16 = 16'h5555; ci16 = 1'b1; iv16 = 1'b1; end
      else iv16 = 1'b0;
      tick();
      chk({tag, " hold_ov"}, 32'(ov16), 32'd1);
      chk({tag, " hold_sum"}, 32'(s16), 32'(es));
      chk({tag, " hold_cout"}, 32'(co16), 32'(eco));
      chk({tag, " hold_ready"}, 32'(ir16), 32'd0);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    tick();
    or16 = 1'b0;
    chk({tag, " ov_drop"}, 32'(ov16), 32'd0);
    chk({tag, " ready_back"}, 32'(ir16), 32'd1);
    chk({tag, " busy_drop"}, 32'(busy16), 32'd0);
    chk({tag, " sum_after"}, 32'(s16), 32'(es));
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] rexp;

    // Reset
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst sum", 32'(s16), 32'd0);
    chk("rst cout", 32'(co16), 32'd0);
    chk("rst out_valid", 32'(ov16), 32'd0);
    chk("rst busy", 32'(busy16), 32'd0);
    chk("rst in_ready", 32'(ir16), 32'd1);
`ifdef RCA_SEQ_OVF_EN
    chk("rst ovf", 32'(ovf16), 32'd0);
`endif

    // Out_ready while idle is harmless
    or16 = 1'b1; tick(); or16 = 1'b0;
    chk("idle out_ready", 32'(ov16), 32'd0);
    chk("idle ready", 32'(ir16), 32'd1);

    op16("basic", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0);
    op16("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    op16("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
    op16("backpr", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 6);

    // Reset mid-RUN at idx=2
    a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst sum", 32'(s16), 32'd0);
    chk("midrst cout", 32'(co16), 32'd0);
    chk("midrst ov", 32'(ov16), 32'd0);
    chk("midrst ready", 32'(ir16), 32'd1);
    chk("midrst busy", 32'(busy16), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("midrst no_result", 32'(ov16), 32'd0);
    end

`ifdef RCA_SEQ_OVF_EN
    op16("ovf1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);
    chk("ovf1 ovf", 32'(ovf16), 32'd1);
    op16("ovf2", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 0);
    chk("ovf2 ovf", 32'(ovf16), 32'd1);
    op16("ovf3", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 0);
    chk("ovf3 ovf", 32'(ovf16), 32'd0);
`endif

    // WIDTH=4: single-cycle RUN
    a4 = 4'h9; b4 = 4'h8; ci4 = 1'b0; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    chk("w4 busy", 32'(busy4), 32'd1);
    chk("w4 ov_run", 32'(ov4), 32'd0);
    tick();
    chk("w4 ov", 32'(ov4), 32'd1);
    chk("w4 sum", 32'(s4), 32'h1);
    chk("w4 cout", 32'(co4), 32'd1);
    or4 = 1'b1;
    tick();
    chk("w4 ov_drop", 32'(ov4), 32'd0);
    chk("w4 ready", 32'(ir4), 32'd1);

    // Back-to-back at NSLICE+2 = 3 cycles, out_ready held high
    for (int n = 0; n < 1000; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      a4 = ra; b4 = rb; ci4 = rc; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      tick();
      chk("w4rnd ov", 32'(ov4), 32'd1);
      chk("w4rnd result", 32'({co4, s4}), 32'(rexp));
      tick();
      chk("w4rnd ready", 32'(ir4), 32'd1);
    end
    or4 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
